pe_dbuf: RTL and testbench
==========================

PE_DBUF -- requirements
Module: pe_dbuf

Interface
REQ-001 Parameter DATA_W, default 8: signed operand width of value and weight.
REQ-002 Parameter ACC_W, default 16: signed width of cumulative and sum_out; ACC_W >= 2*DATA_W is required, and a violation is an elaboration error.
REQ-003 Ports: clk in 1, rising-edge clock; n_rst in 1, reset, asynchronous, active-low.
REQ-004 Ports: stall in 1, freeze pipeline; load in 1, write shadow weight; swap in 1, copy shadow weight to active weight; input_weight in DATA_W, signed.
REQ-005 Ports: input_value in DATA_W, signed; input_valid in 1; cumulative in ACC_W, signed partial sum from the upstream PE.
REQ-006 Ports: mode in 1 (0 = chain sum, 1 = local accumulate); acc_clr in 1; ovf_clr in 1.
REQ-007 Ports: pass_value out DATA_W; pass_valid out 1; sum_out out ACC_W, signed; output_valid out 1; overflow out 1, sticky.

Function
REQ-008 Weight double buffer: load=1 writes input_weight to shadow at the clock edge; swap=1 writes the old shadow value to active at the same edge; load and swap together put the old shadow in active and the new value in shadow.
REQ-009 Load, swap and ovf_clr act regardless of stall.
REQ-010 Stage 1, cycle t, stall=0: value_r <= input_value; pass_valid <= input_valid; pass_value equals value_r (1-cycle latency).
REQ-011 Product = value_r * active weight: a full-precision 2*DATA_W signed product, sign-extended to ACC_W+1 bits.
REQ-012 Stage 2, cycle t+1, stall=0: output_valid <= pass_valid; when pass_valid=1, sum_out <= sat(base + product).
REQ-013 In mode 0, base is cumulative sampled at cycle t+1; sum_out is therefore valid at t+2, aligned with the systolic skew.
REQ-014 In mode 1, base is the current sum_out, or 0 when acc_clr=1 in the same cycle.
REQ-015 acc_clr=1 with pass_valid=0 sets sum_out to 0 and leaves output_valid at 0.
REQ-016 When pass_valid=0 and acc_clr=0, sum_out holds its value and output_valid is 0.
REQ-017 sat(): the add is computed in ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-018 overflow is set on any clamp during a valid stage-2 operation; it stays set until ovf_clr=1.
REQ-019 ovf_clr=1 together with a new clamp leaves overflow at 1 (the set wins).
REQ-020 stall=1 holds value_r, pass_valid, sum_out and output_valid at their current values; no accumulation and no new valid pulse occur while stalled.
REQ-021 A mode change takes effect on the next stage-2 operation; there is no implicit clear.

Reset
REQ-022 n_rst=0 asynchronously clears shadow weight, active weight, value_r, pass_valid, sum_out, output_valid and overflow to 0.
REQ-023 Reset asserted mid-stream discards in-flight data; the first valid result after release appears 2 cycles after the first input_valid.

Structure
REQ-024 Package pe_pkg holds the DATA_W/ACC_W defaults and a mode enum (MODE_CHAIN, MODE_ACC).
REQ-025 Saturating add lives in combinational sub-module pe_sat_add, parametrised by ACC_W, with outputs sum and clamped.
REQ-026 pe_dbuf holds the weight registers, the two pipeline stages, the overflow flag and the multiply.

Verification (DATA_W=8, ACC_W=16)
REQ-027 Chain path: load 3 and swap; value 5 valid at t; cumulative 10 at t+1 -> pass_value=5 at t+1; sum_out=25 with a 1-cycle output_valid at t+2.
REQ-028 Double buffer: active=3, then load 7 with no swap -> products keep using 3; swap -> next product uses 7; load 9 with swap in the same cycle -> active=7, shadow=9.
REQ-029 Saturation: weight 127, value 127, cumulative 32767 -> sum_out=32767 and overflow=1 held until ovf_clr; weight -128, value 127, cumulative -20000 -> sum_out=-32768.
REQ-030 Accumulate: mode=1, weight 2, values 1,2,3 on consecutive cycles, acc_clr with the first -> sum_out 2, 6, 12.
REQ-031 Stall: stall=1 for 3 cycles mid-stream -> outputs frozen and no duplicate output_valid; results resume unchanged after release.
REQ-032 Reset: n_rst pulsed low mid-stream -> all outputs 0 immediately; a fresh sequence after release matches the REQ-027 timing.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared widths and mode encoding for the processing-element slice
package pe_pkg;
  localparam int PE_DATA_W = 8;
  localparam int PE_ACC_W  = 16;
  typedef enum logic {MODE_CHAIN = 1'b0, MODE_ACC = 1'b1} pe_mode_e;
endpackage

// File: rtl/pe_sat_add.sv
// pe_sat_add: adds an ACC_W base to an ACC_W+1 addend and clamps to the ACC_W signed range
module pe_sat_add #(
  parameter int ACC_W = 16
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W:0]   i_b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    clamped
);
  logic signed [ACC_W:0] w_full;
  assign w_full  = {i_a[ACC_W-1], i_a} + i_b;
  // The top two bits disagree only when the true sum left the ACC_W range
  assign clamped = w_full[ACC_W] != w_full[ACC_W-1];
  assign sum     = clamped ? {w_full[ACC_W], {(ACC_W-1){~w_full[ACC_W]}}} : w_full[ACC_W-1:0];
endmodule

// File: rtl/pe_dbuf.sv
// pe_dbuf: systolic MAC element with a double-buffered weight, chain/accumulate modes
// and a saturating two-stage pipeline with a sticky overflow flag
module pe_dbuf import pe_pkg::*; #(
  parameter int DATA_W = PE_DATA_W,
  parameter int ACC_W  = PE_ACC_W
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     stall,
  input  logic                     load,
  input  logic                     swap,
  input  logic signed [DATA_W-1:0] input_weight,
  input  logic signed [DATA_W-1:0] input_value,
  input  logic                     input_valid,
  input  logic signed [ACC_W-1:0]  cumulative,
  input  logic                     mode,
  input  logic                     acc_clr,
  input  logic                     ovf_clr,
  output logic signed [DATA_W-1:0] pass_value,
  output logic                     pass_valid,
  output logic signed [ACC_W-1:0]  sum_out,
  output logic                     output_valid,
  output logic                     overflow
);
  if (ACC_W < 2*DATA_W) begin : g_width_check
    $error("pe_dbuf: ACC_W must be at least 2*DATA_W");
  end
  logic signed [DATA_W-1:0]   r_shadow, r_active, r_value;
  logic                       r_pass_valid, r_out_valid, r_ovf;
  logic signed [ACC_W-1:0]    r_sum, w_base, w_sum;
  logic signed [2*DATA_W-1:0] w_va, w_wa, w_prod;
  logic signed [ACC_W:0]      w_prod_ext;
  logic                       w_clamped, w_stage2;
  assign w_va       = {{DATA_W{r_value[DATA_W-1]}}, r_value};
  assign w_wa       = {{DATA_W{r_active[DATA_W-1]}}, r_active};
  assign w_prod     = w_va * w_wa;
  assign w_prod_ext = {{(ACC_W+1-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_base     = (pe_mode_e'(mode) == MODE_ACC) ? (acc_clr ? '0 : r_sum) : cumulative;
  assign w_stage2   = !stall && r_pass_valid;
  pe_sat_add #(.ACC_W(ACC_W)) u_sat (
    .i_a     (w_base),
    .i_b     (w_prod_ext),
    .sum     (w_sum),
    .clamped (w_clamped)
  );
  // Weight buffers ignore stall so weights can be preloaded while the array is frozen
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (load) r_shadow <= input_weight;
      if (swap) r_active <= r_shadow;
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_value      <= '0;
      r_pass_valid <= 1'b0;
      r_out_valid  <= 1'b0;
      r_sum        <= '0;
    end else if (!stall) begin
      r_value      <= input_value;
      r_pass_valid <= input_valid;
      r_out_valid  <= r_pass_valid;
      if (r_pass_valid) r_sum <= w_sum;
      else if (acc_clr) r_sum <= '0;
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_ovf <= 1'b0;
    else        r_ovf <= (w_stage2 && w_clamped) || (r_ovf && !ovf_clr);
  end
  assign pass_value   = r_value;
  assign pass_valid   = r_pass_valid;
  assign sum_out      = r_sum;
  assign output_valid = r_out_valid;
  assign overflow     = r_ovf;
endmodule

// File: tb/tb_pe_dbuf.sv
// tb_pe_dbuf: randomized + directed bench; an integer reference model feeds a scoreboard
// queue that a separate monitor drains whenever the DUT presents a fresh result
module tb_pe_dbuf;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int MAXV   = (1 << (ACC_W-1)) - 1;
  localparam int MINV   = -(1 << (ACC_W-1));

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic stall = 1'b0, load = 1'b0, swap = 1'b0, input_valid = 1'b0;
  logic mode = 1'b0, acc_clr = 1'b0, ovf_clr = 1'b0;
  logic signed [DATA_W-1:0] input_weight = '0, input_value = '0;
  logic signed [ACC_W-1:0]  cumulative = '0;
  logic signed [DATA_W-1:0] pass_value;
  logic signed [ACC_W-1:0]  sum_out;
  logic pass_valid, output_valid, overflow;

  pe_dbuf #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .n_rst(n_rst), .stall(stall), .load(load), .swap(swap),
    .input_weight(input_weight), .input_value(input_value), .input_valid(input_valid),
    .cumulative(cumulative), .mode(mode), .acc_clr(acc_clr), .ovf_clr(ovf_clr),
    .pass_value(pass_value), .pass_valid(pass_valid), .sum_out(sum_out),
    .output_valid(output_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  logic stall_q = 1'b0;

  // Reference model state: plain integers describing what the PE should hold
  int m_shadow, m_active, m_val, m_sum;
  bit m_pv, m_ov, m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shadow = 0; m_active = 0; m_val = 0; m_sum = 0;
    m_pv = 0; m_ov = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  // Predicts the effect of the next rising edge from the inputs currently applied
  task automatic model_step();
    int base, full;
    bit set;
    set = 0;
    if (!stall) begin
      if (m_pv) begin
        base = mode ? (acc_clr ? 0 : m_sum) : int'(cumulative);
        full = base + m_val * m_active;
        if (full > MAXV) begin full = MAXV; set = 1; end
        if (full < MINV) begin full = MINV; set = 1; end
        m_sum = full;
        exp_q.push_back(full);
      end else if (acc_clr) m_sum = 0;
      m_ov = m_pv;
      m_pv = input_valid;
      m_val = int'(input_value);
    end
    m_ovf = set || (m_ovf && !ovf_clr);
    if (swap) m_active = m_shadow;
    if (load) m_shadow = int'(input_weight);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("pass_value", int'(pass_value), m_val);
    chk("pass_valid", int'(pass_valid), int'(m_pv));
    chk("output_valid", int'(output_valid), int'(m_ov));
    chk("sum_out", int'(sum_out), m_sum);
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic idle();
    stall = 0; load = 0; swap = 0; input_valid = 0; acc_clr = 0; ovf_clr = 0;
  endtask

  task automatic set_weight(input int w);
    idle(); load = 1; input_weight = DATA_W'(w); tick();
    load = 0; swap = 1; tick(); swap = 0;
  endtask

  task automatic chain_test();
    idle(); mode = 0; cumulative = '0;
    set_weight(3);
    input_value = 5; input_valid = 1; tick();
    chk("chain pass_value", int'(pass_value), 5);
    input_valid = 0; cumulative = 10; tick();
    chk("chain sum_out", int'(sum_out), 25);
    chk("chain output_valid pulse", int'(output_valid), 1);
    cumulative = 0; tick();
    chk("chain output_valid drop", int'(output_valid), 0);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, " pass_value"}, int'(pass_value), 0);
    chk({tag, " pass_valid"}, int'(pass_valid), 0);
    chk({tag, " sum_out"}, int'(sum_out), 0);
    chk({tag, " output_valid"}, int'(output_valid), 0);
    chk({tag, " overflow"}, int'(overflow), 0);
  endtask

  always @(posedge clk) stall_q <= stall;

  // Monitor: a fresh result is output_valid after an edge that was not stalled
  always @(negedge clk) begin
    if (n_rst && output_valid && !stall_q) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL scoreboard: unexpected result %0d with nothing queued", sum_out);
      end else chk("scoreboard sum_out", int'(sum_out), exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    zero_check("reset");
    n_rst = 1;
    // Chain path
    chain_test();
    // Double buffer: shadow writes stay invisible until swapped
    idle(); input_value = 2; input_valid = 1; load = 1; input_weight = 7; tick();
    idle(); tick();
    chk("dbuf old weight", int'(sum_out), 6);
    swap = 1; input_value = 2; input_valid = 1; tick();
    idle(); tick();
    chk("dbuf swapped weight", int'(sum_out), 14);
    load = 1; swap = 1; input_weight = 9; input_value = 1; input_valid = 1; tick();
    idle(); tick();
    chk("dbuf load+swap active", int'(sum_out), 7);
    swap = 1; input_value = 1; input_valid = 1; tick();
    idle(); tick();
    chk("dbuf load+swap shadow", int'(sum_out), 9);
    // Saturation and sticky overflow
    set_weight(127);
    input_value = 127; input_valid = 1; tick();
    idle(); cumulative = 16'sd32767; tick();
    chk("sat pos sum_out", int'(sum_out), 32767);
    chk("sat pos overflow", int'(overflow), 1);
    cumulative = 0; tick(); tick();
    chk("overflow sticky", int'(overflow), 1);
    ovf_clr = 1; tick(); ovf_clr = 0;
    chk("overflow cleared", int'(overflow), 0);
    set_weight(-128);
    input_value = 127; input_valid = 1; tick();
    idle(); cumulative = -16'sd20000; ovf_clr = 1; tick(); ovf_clr = 0;
    chk("sat neg sum_out", int'(sum_out), -32768);
    chk("set beats ovf_clr", int'(overflow), 1);
    ovf_clr = 1; tick(); idle();
    // Local accumulate
    mode = 1; set_weight(2);
    input_valid = 1; input_value = 1; acc_clr = 1; tick();
    acc_clr = 0; input_value = 2; tick();
    chk("acc first", int'(sum_out), 2);
    input_value = 3; tick();
    chk("acc second", int'(sum_out), 6);
    input_valid = 0; tick();
    chk("acc third", int'(sum_out), 12);
    // Stall mid-stream in chain mode
    idle(); mode = 0; set_weight(4);
    for (int i = 1; i <= 6; i++) begin
      input_value = DATA_W'(i); input_valid = 1; cumulative = ACC_W'(100 * i);
      stall = (i >= 3 && i <= 5);
      tick();
    end
    idle(); tick(); tick();
    // Randomized traffic with a mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        input_valid = 1; input_value = 9;
        #2 n_rst = 0;
        #1 zero_check("async reset");
        model_reset();
        @(negedge clk); @(negedge clk);
        n_rst = 1;
        chain_test();
      end
      stall        = ($urandom_range(0, 4) == 0);
      load         = ($urandom_range(0, 3) == 0);
      swap         = ($urandom_range(0, 5) == 0);
      acc_clr      = ($urandom_range(0, 9) == 0);
      ovf_clr      = ($urandom_range(0, 9) == 0);
      input_valid  = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      input_weight = DATA_W'($urandom);
      input_value  = DATA_W'($urandom);
      cumulative   = ACC_W'($urandom);
      tick();
    end
    idle(); tick(); tick();
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
